serial_image_rx: RTL and testbench

- Upstream input stage of the digit classifier.
- Receives a 784-bit binarised 28x28 image over a two-wire serial link (serialClock/serialData on ARDUINO_IO[1:0]) that is asynchronous to CLOCK_50.
- Synchronises and deserialises the stream, then presents the complete image to the network input layer with a valid/ready handshake.
- Detects stalled partial frames and overruns.

---
 rtl/serial_image_rx_if.sv | 21 ++
 rtl/serial_image_rx.sv | 214 +++++++++++++++++++++
 tb/tb_serial_image_rx.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/serial_image_rx_if.sv
// Image hand-off bus between the serial receiver and the network input layer.
// The receiver drives the frame and its valid flag; the consumer returns ready.
interface serial_image_rx_if #(
  parameter int IMG_BITS = 784
) ();
  logic [IMG_BITS-1:0] image_data;
  logic                image_valid;
  logic                image_ready;

  modport master (
    output image_data,
    output image_valid,
    input  image_ready
  );

  modport slave (
    input  image_data,
    input  image_valid,
    output image_ready
  );
endinterface

// File: rtl/serial_image_rx.sv
// serial_image_rx: synchronises an asynchronous two-wire serial link to the
// system clock, deserialises one binarised image frame (MSB first) and hands
// it to the consumer over a valid/ready bus. A stalled partial frame is
// abandoned after TIMEOUT_CYCLES idle cycles; bits that cannot be stored
// raise a sticky overrun flag.
// Optional build macro SERIAL_RX_DBUF_EN: adds a separate receive shift
// register so reception continues while a completed frame is held.
module serial_image_rx #(
  parameter int IMG_BITS       = 784,
  parameter int CNT_W          = 10,
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic              i_clock_50,
  input  logic              i_reset,
  input  logic              i_serial_clock,
  input  logic              i_serial_data,
  serial_image_rx_if.master bus,
  output logic              o_busy,
  output logic [CNT_W-1:0]  o_bit_count,
  output logic              o_frame_error,
  output logic              o_overrun
);

  localparam int TMO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  typedef enum logic [0:0] {
    ST_RECV = 1'b0,
    ST_HOLD = 1'b1
  } state_t;

  state_t r_state;
  state_t w_state_next;

  logic [SYNC_STAGES-1:0] r_sclk_sync;
  logic [SYNC_STAGES-1:0] r_sdat_sync;
  logic                   r_sclk_prev;
  logic                   w_edge;
  logic                   w_bit;

  logic [IMG_BITS-1:0] r_data;
  logic [IMG_BITS-1:0] w_data_next;
  logic                r_valid;
  logic                w_valid_next;
  logic [CNT_W-1:0]    r_bit_count;
  logic [CNT_W-1:0]    w_count_next;
  logic                r_busy;
  logic [TMO_W-1:0]    r_tmo;
  logic [TMO_W-1:0]    w_tmo_next;
  logic                r_frame_error;
  logic                w_ferr_next;
  logic                r_overrun;
  logic                w_ovr_next;
  logic                w_accept;
  logic                w_last_bit;
`ifdef SERIAL_RX_DBUF_EN
  logic [IMG_BITS-1:0] r_shift;
  logic [IMG_BITS-1:0] w_shift_next;
`endif

  // Two-flop (or deeper) synchronisers for both link wires plus the edge-detect history.
  always_ff @(posedge i_clock_50) begin
    if (i_reset) begin
      r_sclk_sync <= '0;
      r_sdat_sync <= '0;
      r_sclk_prev <= 1'b0;
    end else begin
      r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], i_serial_clock};
      r_sdat_sync <= {r_sdat_sync[SYNC_STAGES-2:0], i_serial_data};
      r_sclk_prev <= r_sclk_sync[SYNC_STAGES-1];
    end
  end

  // Data is taken from the same synchroniser depth as the clock so both are aligned.
  assign w_edge     = r_sclk_sync[SYNC_STAGES-1] & ~r_sclk_prev;
  assign w_bit      = r_sdat_sync[SYNC_STAGES-1];
  assign w_accept   = r_valid & bus.image_ready;
  assign w_last_bit = (r_bit_count == CNT_W'(IMG_BITS - 1));

  // State register of the receive/hold controller.
  always_ff @(posedge i_clock_50) begin
    if (i_reset) begin
      r_state <= ST_RECV;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state and next-datapath values for reception, hand-off and timeout.
  always_comb begin
    w_state_next = r_state;
    w_data_next  = r_data;
    w_valid_next = r_valid;
    w_count_next = r_bit_count;
    w_tmo_next   = r_tmo;
    w_ferr_next  = 1'b0;
    w_ovr_next   = r_overrun;
`ifdef SERIAL_RX_DBUF_EN
    w_shift_next = r_shift;
`endif
    case (r_state)
      ST_RECV: begin
`ifdef SERIAL_RX_DBUF_EN
        // Held frame leaves independently of the receive shift register.
        if (w_accept) begin
          w_valid_next = 1'b0;
          w_ovr_next   = 1'b0;
        end else begin
          w_valid_next = r_valid;
        end
        if (w_edge) begin
          w_shift_next = {r_shift[IMG_BITS-2:0], w_bit};
          w_tmo_next   = '0;
          if (w_last_bit) begin
            w_count_next = '0;
            if (!r_valid || w_accept) begin
              w_data_next  = w_shift_next;
              w_valid_next = 1'b1;
            end else begin
              w_ovr_next   = 1'b1;
            end
          end else begin
            w_count_next = r_bit_count + CNT_W'(1'b1);
          end
        end else if (r_bit_count != '0) begin
          if (r_tmo == TMO_W'(TIMEOUT_CYCLES - 1)) begin
            w_count_next = '0;
            w_tmo_next   = '0;
            w_ferr_next  = 1'b1;
          end else begin
            w_tmo_next   = r_tmo + TMO_W'(1'b1);
          end
        end else begin
          w_tmo_next = '0;
        end
`else
        if (w_edge) begin
          w_data_next = {r_data[IMG_BITS-2:0], w_bit};
          w_tmo_next  = '0;
          if (w_last_bit) begin
            // Valid rises on the same edge as the final shift.
            w_count_next = '0;
            w_valid_next = 1'b1;
            w_state_next = ST_HOLD;
          end else begin
            w_count_next = r_bit_count + CNT_W'(1'b1);
          end
        end else if (r_bit_count != '0) begin
          if (r_tmo == TMO_W'(TIMEOUT_CYCLES - 1)) begin
            w_count_next = '0;
            w_tmo_next   = '0;
            w_ferr_next  = 1'b1;
          end else begin
            w_tmo_next   = r_tmo + TMO_W'(1'b1);
          end
        end else begin
          w_tmo_next = '0;
        end
`endif
      end
      ST_HOLD: begin
        w_tmo_next = '0;
        // An edge coinciding with the accept is silently dropped.
        if (w_accept) begin
          w_valid_next = 1'b0;
          w_ovr_next   = 1'b0;
          w_state_next = ST_RECV;
        end else if (w_edge) begin
          w_ovr_next   = 1'b1;
        end else begin
          w_ovr_next   = r_overrun;
        end
      end
      default: begin
        w_state_next = ST_RECV;
      end
    endcase
  end

  // Datapath and status registers; busy is registered alongside the bit counter.
  always_ff @(posedge i_clock_50) begin
    if (i_reset) begin
      r_data        <= '0;
      r_valid       <= 1'b0;
      r_bit_count   <= '0;
      r_busy        <= 1'b0;
      r_tmo         <= '0;
      r_frame_error <= 1'b0;
      r_overrun     <= 1'b0;
`ifdef SERIAL_RX_DBUF_EN
      r_shift       <= '0;
`endif
    end else begin
      r_data        <= w_data_next;
      r_valid       <= w_valid_next;
      r_bit_count   <= w_count_next;
      r_busy        <= (w_count_next != '0);
      r_tmo         <= w_tmo_next;
      r_frame_error <= w_ferr_next;
      r_overrun     <= w_ovr_next;
`ifdef SERIAL_RX_DBUF_EN
      r_shift       <= w_shift_next;
`endif
    end
  end

  assign bus.image_data  = r_data;
  assign bus.image_valid = r_valid;
  assign o_busy          = r_busy;
  assign o_bit_count     = r_bit_count;
  assign o_frame_error   = r_frame_error;
  assign o_overrun       = r_overrun;

endmodule

// File: tb/tb_serial_image_rx.sv
// Self-checking bench for serial_image_rx: random frames are serialised MSB
// first, each frame that must reach the consumer is queued, and a monitor
// compares every accepted transfer against the head of the queue.
module tb_serial_image_rx;
  localparam int IMG_BITS = 784;
  localparam int CNT_W    = 10;

  logic             clk;
  logic             rst;
  logic             sclk;
  logic             sdat;
  logic             busy;
  logic [CNT_W-1:0] bit_count;
  logic             frame_error;
  logic             overrun;

  serial_image_rx_if #(.IMG_BITS(IMG_BITS)) bus ();

  serial_image_rx #(
    .IMG_BITS(IMG_BITS),
    .CNT_W(CNT_W),
    .SYNC_STAGES(2),
    .TIMEOUT_CYCLES(64)
  ) dut (
    .i_clock_50(clk),
    .i_reset(rst),
    .i_serial_clock(sclk),
    .i_serial_data(sdat),
    .bus(bus),
    .o_busy(busy),
    .o_bit_count(bit_count),
    .o_frame_error(frame_error),
    .o_overrun(overrun)
  );

  int n_checks = 0;
  int n_errors = 0;
  int n_valid_cycles = 0;
  logic [IMG_BITS-1:0] exp_q[$];
  logic [IMG_BITS-1:0] mon_exp;
  logic [IMG_BITS-1:0] f1, f2, f3, f4, fa, fb;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [IMG_BITS-1:0] act,
                       input logic [IMG_BITS-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Stimulus moves shortly after the rising edge, well clear of both clock edges.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Serialise bits [from, upto) of a frame; bit i of the stream is v[IMG_BITS-1-i].
  task automatic send_bits(input logic [IMG_BITS-1:0] v, input int from,
                           input int upto, input int half);
    for (int i = from; i < upto; i++) begin
      sdat = v[IMG_BITS-1-i];
      repeat (half) tick();
      sclk = 1'b1;
      repeat (half) tick();
      sclk = 1'b0;
    end
  endtask

  function automatic logic [IMG_BITS-1:0] rand_frame();
    logic [IMG_BITS-1:0] v;
    for (int i = 0; i < IMG_BITS; i++) v[i] = 1'($urandom_range(1, 0));
    return v;
  endfunction

  task automatic pulse_ready();
    bus.image_ready = 1'b1;
    tick();
    bus.image_ready = 1'b0;
    tick();
  endtask

  // Monitor: every accepted transfer must match the oldest expected frame.
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.image_valid) n_valid_cycles++;
      if (bus.image_valid && bus.image_ready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL unexpected_frame got=%0h expected=none", bus.image_data);
        end else begin
          mon_exp = exp_q.pop_front();
          check("frame_data", bus.image_data, mon_exp);
        end
      end
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog got=no_finish expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int nfe;
    rst = 1'b1;
    sclk = 1'b0;
    sdat = 1'b0;
    bus.image_ready = 1'b0;
    repeat (4) tick();
    check("rst_data", bus.image_data, '0);
    check("rst_valid", bus.image_valid, 0);
    check("rst_count", bit_count, 0);
    check("rst_busy", busy, 0);
    check("rst_ferr", frame_error, 0);
    check("rst_ovr", overrun, 0);
    rst = 1'b0;
    repeat (2) tick();

    // Frame 1: 29 zeros, 3 ones, random remainder, slow link.
    f1 = rand_frame();
    for (int i = 0; i < 32; i++) f1[IMG_BITS-1-i] = (i >= 29);
    exp_q.push_back(f1);
    send_bits(f1, 0, IMG_BITS, 10);
    check("f1_valid", bus.image_valid, 1);
    check("f1_ones", bus.image_data[754:752], 3'b111);
    check("f1_zeros", bus.image_data[783:755], 0);
    check("f1_count", bit_count, 0);
    check("f1_busy", busy, 0);

    // Extra edges while the frame is held.
    f2 = rand_frame();
    send_bits(f2, 0, 5, 10);
`ifdef SERIAL_RX_DBUF_EN
    check("hold_ovr", overrun, 0);
    check("hold_count", bit_count, 5);
`else
    check("hold_ovr", overrun, 1);
    check("hold_count", bit_count, 0);
`endif
    check("hold_data", bus.image_data, f1);
    check("hold_valid", bus.image_valid, 1);
    pulse_ready();
    check("acc_valid", bus.image_valid, 0);
    check("acc_ovr", overrun, 0);
`ifdef SERIAL_RX_DBUF_EN
    repeat (100) tick();
`endif

    // Stalled partial frame, then a clean frame.
    send_bits(f2, 0, 100, 5);
    check("part_count", bit_count, 100);
    check("part_busy", busy, 1);
    nfe = 0;
    repeat (200) begin
      tick();
      if (frame_error) nfe++;
    end
    check("ferr_pulses", nfe, 1);
    check("tmo_count", bit_count, 0);
    check("tmo_busy", busy, 0);
    f3 = rand_frame();
    exp_q.push_back(f3);
    send_bits(f3, 0, IMG_BITS, 5);
    check("f3_valid", bus.image_valid, 1);
    pulse_ready();

    // Reset in the middle of a frame.
    send_bits(rand_frame(), 0, 400, 5);
    rst = 1'b1;
    repeat (2) tick();
    check("mrst_data", bus.image_data, '0);
    check("mrst_valid", bus.image_valid, 0);
    check("mrst_count", bit_count, 0);
    check("mrst_busy", busy, 0);
    check("mrst_ovr", overrun, 0);
    rst = 1'b0;
    tick();
    f4 = rand_frame();
    exp_q.push_back(f4);
    send_bits(f4, 0, IMG_BITS, 5);
    pulse_ready();

    // Back-to-back frames with ready tied high.
    n_valid_cycles = 0;
    bus.image_ready = 1'b1;
    fa = '1;
    fb = {(IMG_BITS/2){2'b10}};
    exp_q.push_back(fa);
    exp_q.push_back(fb);
    send_bits(fa, 0, IMG_BITS, 5);
    send_bits(fb, 0, IMG_BITS, 5);
    repeat (4) tick();
    bus.image_ready = 1'b0;
    check("b2b_pulses", n_valid_cycles, 2);
    check("b2b_ovr", overrun, 0);

`ifdef SERIAL_RX_DBUF_EN
    // Second frame arrives while the first is still held: it is dropped.
    fa = rand_frame();
    fb = rand_frame();
    exp_q.push_back(fa);
    send_bits(fa, 0, IMG_BITS, 5);
    send_bits(fb, 0, IMG_BITS, 5);
    check("dbuf_keep", bus.image_data, fa);
    check("dbuf_ovr", overrun, 1);
    pulse_ready();
    // Consumer frees the buffer before the second frame completes.
    fa = rand_frame();
    fb = rand_frame();
    exp_q.push_back(fa);
    exp_q.push_back(fb);
    send_bits(fa, 0, IMG_BITS, 5);
    send_bits(fb, 0, 700, 5);
    bus.image_ready = 1'b1;
    send_bits(fb, 700, IMG_BITS, 5);
    bus.image_ready = 1'b0;
    tick();
    check("dbuf_second", bus.image_data, fb);
    check("dbuf_ovr2", overrun, 0);
`endif

    repeat (4) tick();
    check("queue_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
